// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC and the fetch packet type.
package fetch_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// rtl/fetch_skid_fifo.sv - 2-entry skid FIFO of fetch packets with flush.
module fetch_skid_fifo
   import fetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic       flush_i,
   input  fetch_pkt_t data_i,
   output fetch_pkt_t head_o,
   output logic [1:0] count_o
);

   fetch_pkt_t mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic [1:0] count_d;

   always_comb begin
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   // Head reads as zero when empty so decode never sees stale packets.
   assign head_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, in-flight read tracking, issue credit.
module instr_fetch
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc
);

   logic [ADDR_W-1:0] pc_q;
   logic              req_valid_q;
   logic [ADDR_W-1:0] req_pc_q;
   logic [1:0]        count;
   logic              pop;
   logic              push;
   logic              issue;
   logic [2:0]        credit;
   fetch_pkt_t        push_pkt;
   fetch_pkt_t        head_pkt;

   assign imem_addr = redirect_valid ? redirect_addr : pc_q;
   assign out_valid = (count != 2'd0) & ~redirect_valid;
   assign pop       = out_valid & out_ready;
   assign push      = req_valid_q & ~redirect_valid;

   // Occupancy after this cycle, counting the word still in the memory pipe.
   assign credit = {1'b0, count} + {2'b0, req_valid_q} - {2'b0, pop};
   assign issue  = credit < 3'd2;

   assign push_pkt.pc    = req_pc_q;
   assign push_pkt.instr = imem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         req_valid_q <= 1'b0;
         req_pc_q    <= '0;
      end else if (redirect_valid) begin
         req_valid_q <= 1'b1;
         req_pc_q    <= redirect_addr;
         pc_q        <= redirect_addr + ADDR_W'(1);
      end else if (issue) begin
         req_valid_q <= 1'b1;
         req_pc_q    <= pc_q;
         pc_q        <= pc_q + ADDR_W'(1);
      end else begin
         req_valid_q <= 1'b0;
      end
   end

   fetch_skid_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .data_i  (push_pkt),
      .head_o  (head_pkt),
      .count_o (count)
   );

   assign out_instr = head_pkt.instr;
   assign out_pc    = head_pkt.pc;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the synchronous instruction memory, and of the decoder on its output side.
- Generates the word address, absorbs the memory's 1-cycle registered read latency, and buffers returned words in a 2-entry skid FIFO.
- Delivers {pc, instr} to decode over a valid/ready handshake.
- Supports a branch redirect that flushes all wrong-path words.

Parameters:
ADDR_W, 7, word-address width; PC wraps modulo 2^ADDR_W
DATA_W, 32, instruction width
RESET_PC, 0, first word address fetched after reset

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
imem_addr  out  ADDR_W  word address to instruction memory; sampled by memory at posedge
imem_rdata  in  DATA_W  memory output; valid one cycle after the address edge (memory output resets to 0)
redirect_valid  in  1  redirect request (branch taken), single-cycle pulse
redirect_addr  in  ADDR_W  redirect target word address
out_valid  out  1  fetched instruction available
out_ready  in  1  decode accepts this cycle
out_instr  out  DATA_W  instruction word at FIFO head
out_pc  out  ADDR_W  word address of out_instr

Behaviour:
- State: pc_q (next fetch address), req_valid_q / req_pc_q (read in flight), 2-entry FIFO {pc, instr} with count 0..2.
- Reset values: pc_q=RESET_PC, req_valid_q=0, req_pc_q=0, count=0.
  - Outputs during reset: out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
  - Reset mid-operation discards everything immediately (asynchronous clear).
- imem_addr = redirect_valid ? redirect_addr : pc_q (combinational).
- pop = out_valid & out_ready.
- push = req_valid_q; entry {req_pc_q, imem_rdata} enters the FIFO tail.
- issue = (count + req_valid_q - pop) < 2. Credit check guarantees a push never meets a full FIFO.
- On issue: req_valid_q<=1, req_pc_q<=pc_q, pc_q<=pc_q+1 (127+1 -> 0). Otherwise req_valid_q<=0 and pc_q holds.
- Steady state with out_ready=1: one instruction per cycle, no bubbles.
- out_valid = (count!=0) & ~redirect_valid. out_instr/out_pc are the FIFO head; they are 0 when empty.
- Redirect has priority over pop, push and issue in the same cycle:
  - count<=0 (in-flight and buffered words dropped; no handshake occurs that cycle).
  - req_valid_q<=1, req_pc_q<=redirect_addr, pc_q<=redirect_addr+1.
- Latency: first out_valid is 2 cycles after the first clk edge following rst_n release. A redirect asserted in cycle N yields out_valid with out_pc=target in cycle N+2.
- Stall: while out_ready=0, the FIFO fills to 2 and issue stops. pc_q holds and no words are lost or duplicated.
- Back-to-back redirects: the latest wins, and the earlier target is dropped.
- Memory output of 0 after reset is never pushed, because req_valid_q=0.
- Order and pc/instr pairing are preserved across stalls and wrap.

Decomposition:
- Package fetch_pkg: ADDR_W, DATA_W, RESET_PC constants; typedef fetch_pkt_t {pc[ADDR_W-1:0], instr[DATA_W-1:0]}.
- Sub-module fetch_skid_fifo: 2-entry FIFO of fetch_pkt_t with push/pop/flush and count output. Top holds the PC, in-flight tracking and issue credit.

Test Plan:
- Memory model: behavioural 1-cycle synchronous memory, word k = 0x1000_0000+k.
- Reset release, out_ready=1 -> out_valid first high 2 cycles after the release edge; outputs pc 0,1,2,... with instr 0x10000000, 0x10000001, ... one per cycle.
- out_ready=0 for 5 cycles after pc 3 is presented -> pc 3 is held stable and count saturates at 2. On release, pcs 3,4,5 follow consecutively with no gap, drop or duplicate.
- redirect_valid pulse to 0x40 while the FIFO is full -> out_valid=0 in that cycle and the next; in cycle N+2 out_pc=0x40, instr=0x10000040; no stale pc appears.
- redirect to 0x7E, out_ready=1 -> pcs 0x7E, 0x7F, 0x00, 0x01 in sequence (wrap).
- rst_n asserted mid-stream with the FIFO holding 2 entries -> out_valid=0 and imem_addr=RESET_PC immediately. After release, the stream restarts from pc 0.
- Randomised out_ready (50%) over 500 cycles -> scoreboard confirms accepted pcs are strictly sequential mod 128 and each instr matches the model.
